// File: rtl/spectrum_matrix_renderer.sv
// spectrum_matrix_renderer
// Reads one magnitude per band on each frame strobe and quantises it to a bar height of
// 0..HEIGHT. It then streams BANDS*HEIGHT GRB pixels column-major to a WS2812 driver,
// with a row colour gradient and global brightness applied. Odd columns can optionally
// be emitted top-to-bottom for serpentine wiring.
// Optional feature: define SPECTRUM_RENDER_PEAK_EN for peak-hold storage, the decay
// counter and bar+peak rendering (mode 2). When undefined, mode 2 renders as a plain bar.
module spectrum_matrix_renderer #(
  parameter int BANDS      = 32,
  parameter int HEIGHT     = 8,
  parameter int ADDR_W     = 5,
  parameter int MAG_W      = 16,
  parameter int SERPENTINE = 1,
  parameter int PEAK_DECAY = 4
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic              spec_frame_stb,
  output logic [ADDR_W-1:0] spec_rd_addr,
  output logic              spec_rd_en,
  input  logic [MAG_W-1:0]  spec_rd_data,
  input  logic              spec_rd_data_valid,
  input  logic [1:0]        mode,
  input  logic [7:0]        brightness,
  output logic [23:0]       led_data,
  output logic              valid,
  output logic              start,
  input  logic              done_bit_in,
  input  logic              done_dz_in,
  output logic              busy,
  output logic [7:0]        drop_cnt
);
  localparam int LVL_W  = $clog2(HEIGHT + 1);
  localparam int ROW_W  = $clog2(HEIGHT);
  localparam int PROD_W = MAG_W + LVL_W;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_START   = 3'd3;
  localparam logic [2:0] ST_EMIT    = 3'd4;
  localparam logic [2:0] ST_WAIT_DZ = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(BANDS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(HEIGHT - 1);
  localparam logic [ROW_W-1:0]  ROW_HALF = ROW_W'(HEIGHT / 2);
  localparam logic [ROW_W-1:0]  ROW_3Q   = ROW_W'((3 * HEIGHT) / 4);

  if (BANDS < 2 || HEIGHT < 4 || (HEIGHT % 4) != 0 || PEAK_DECAY < 1 ||
      (1 << ADDR_W) < BANDS) begin : g_param_err
    $error("spectrum_matrix_renderer: illegal parameter combination");
  end

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_band;
  logic [ADDR_W-1:0] r_col;
  logic [ROW_W-1:0]  r_row;
  logic [1:0]        r_mode;
  logic [7:0]        r_bright;
  logic              r_busy;
  logic              r_start;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [23:0]       r_led;
  logic              r_valid;
  logic [7:0]        r_drop;
  logic [LVL_W-1:0]  r_level [BANDS];

  logic [LVL_W-1:0]  w_level;
  logic [ADDR_W-1:0] w_ncol;
  logic [ROW_W-1:0]  w_nrow;
  logic [ROW_W-1:0]  w_prow;
  logic              w_last;
  logic [23:0]       w_pix;

  // mag*(HEIGHT+1) never overflows PROD_W bits, so the top LVL_W bits are the level.
  assign w_level = LVL_W'((PROD_W'(spec_rd_data) * PROD_W'(HEIGHT + 1)) >> MAG_W);
  assign w_last  = (r_col == LAST_COL) && (r_row == LAST_ROW);

  // Brightness 255 means full scale, so a saturated channel reaches 0xFF.
  function automatic logic [7:0] f_scale(input logic [7:0] c, input logic [7:0] br);
    logic [15:0] p;
    p = {8'd0, c} * {8'd0, br};
    return (br == 8'hFF) ? c : 8'(p >> 8);
  endfunction

  // Index of the pixel to load next: pixel 0 from START, otherwise the successor of r_col/r_row.
  always_comb begin
    w_ncol = '0;
    w_nrow = '0;
    if (r_state == ST_EMIT) begin
      if (r_row == LAST_ROW) begin
        w_ncol = r_col + ADDR_W'(1);
      end else begin
        w_ncol = r_col;
        w_nrow = r_row + ROW_W'(1);
      end
    end
  end

  assign w_prow = (SERPENTINE != 0 && w_ncol[0]) ? (LAST_ROW - w_nrow) : w_nrow;

`ifdef SPECTRUM_RENDER_PEAK_EN
  localparam int FC_W = (PEAK_DECAY > 1) ? $clog2(PEAK_DECAY) : 1;

  logic [LVL_W-1:0] r_peak [BANDS];
  logic [FC_W-1:0]  r_fcnt;
  logic             w_tick;

  assign w_tick = (r_fcnt == FC_W'(PEAK_DECAY - 1));

  // Peak hold per band; decay is applied only in frames where the frame counter ticks.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_fcnt <= '0;
      for (int i = 0; i < BANDS; i++) r_peak[i] <= '0;
    end else if (r_state == ST_RD_WAIT && spec_rd_data_valid) begin
      if (w_level > r_peak[r_band]) begin
        r_peak[r_band] <= w_level;
      end else if (w_tick && r_peak[r_band] > w_level) begin
        r_peak[r_band] <= r_peak[r_band] - LVL_W'(1);
      end
      if (r_band == LAST_COL) r_fcnt <= w_tick ? '0 : r_fcnt + FC_W'(1);
    end
  end
`endif

  // Pixel colour for (w_ncol, w_prow): gradient base, lit mask, optional white peak, scaling.
  always_comb begin
    logic [LVL_W-1:0] lvl;
    logic [LVL_W-1:0] row_l;
    logic             lit;
    logic [7:0]       g;
    logic [7:0]       r;
    logic [7:0]       b;
    lvl   = r_level[w_ncol];
    row_l = LVL_W'(w_prow);
    lit   = (r_mode == 2'd1) ? ((lvl != '0) && (row_l + LVL_W'(1) == lvl)) : (row_l < lvl);
    b     = 8'h00;
    if (w_prow < ROW_HALF) begin
      g = 8'hFF;
      r = 8'h00;
    end else if (w_prow < ROW_3Q) begin
      g = 8'hFF;
      r = 8'hFF;
    end else begin
      g = 8'h00;
      r = 8'hFF;
    end
    if (!lit) begin
      g = 8'h00;
      r = 8'h00;
    end
`ifdef SPECTRUM_RENDER_PEAK_EN
    if (r_mode == 2'd2 && r_peak[w_ncol] > lvl && row_l + LVL_W'(1) == r_peak[w_ncol]) begin
      g = 8'hFF;
      r = 8'hFF;
      b = 8'hFF;
    end
`endif
    w_pix = {f_scale(g, r_bright), f_scale(r, r_bright), f_scale(b, r_bright)};
  end

  // Frame sequencer: band reads, start pulse, pixel handshake, wait for the driver's reset gap.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_band    <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_mode    <= '0;
      r_bright  <= '0;
      r_busy    <= 1'b0;
      r_start   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_led     <= '0;
      r_valid   <= 1'b0;
      r_drop    <= '0;
      for (int i = 0; i < BANDS; i++) r_level[i] <= '0;
    end else begin
      r_rd_en <= 1'b0;
      if (spec_frame_stb && r_state != ST_IDLE && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      case (r_state)
        ST_IDLE: begin
          if (spec_frame_stb) begin
            r_mode   <= mode;
            r_bright <= brightness;
            r_busy   <= 1'b1;
            r_band   <= '0;
            r_state  <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          r_rd_addr <= r_band;
          r_rd_en   <= 1'b1;
          r_state   <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (spec_rd_data_valid) begin
            r_level[r_band] <= w_level;
            if (r_band == LAST_COL) begin
              r_start <= 1'b1;
              r_state <= ST_START;
            end else begin
              r_band  <= r_band + ADDR_W'(1);
              r_state <= ST_RD_REQ;
            end
          end
        end
        ST_START: begin
          // Pixel 0 is registered here so valid rises together with entry to EMIT.
          r_start <= 1'b0;
          r_led   <= w_pix;
          r_valid <= 1'b1;
          r_col   <= '0;
          r_row   <= '0;
          r_state <= ST_EMIT;
        end
        ST_EMIT: begin
          if (done_bit_in) begin
            if (w_last) begin
              r_valid <= 1'b0;
              r_state <= ST_WAIT_DZ;
            end else begin
              r_col <= w_ncol;
              r_row <= w_nrow;
              r_led <= w_pix;
            end
          end
        end
        ST_WAIT_DZ: begin
          if (done_dz_in) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign spec_rd_addr = r_rd_addr;
  assign spec_rd_en   = r_rd_en;
  assign led_data     = r_led;
  assign valid        = r_valid;
  assign start        = r_start;
  assign busy         = r_busy;
  assign drop_cnt     = r_drop;

endmodule

// File: tb/tb_spectrum_matrix_renderer.sv
// Scoreboard bench for spectrum_matrix_renderer (BANDS=32, HEIGHT=8, serpentine, decay 4).
// Expected pixels for each frame are queued when the strobe is issued; a negedge monitor
// pops and compares each pixel the driver consumes. Peak checks follow SPECTRUM_RENDER_PEAK_EN.
`timescale 1ns/1ps
module tb_spectrum_matrix_renderer;
  localparam int BANDS      = 32;
  localparam int HEIGHT     = 8;
  localparam int NPIX       = BANDS * HEIGHT;
  localparam int PEAK_DECAY = 4;
  localparam int LIMIT      = 20000;

  logic        clk_50m = 1'b0;
  logic        rst = 1'b1;
  logic        spec_frame_stb = 1'b0;
  logic [4:0]  spec_rd_addr;
  logic        spec_rd_en;
  logic [15:0] spec_rd_data = '0;
  logic        spec_rd_data_valid = 1'b0;
  logic [1:0]  mode = '0;
  logic [7:0]  brightness = '0;
  logic [23:0] led_data;
  logic        valid;
  logic        start;
  logic        done_bit_in = 1'b0;
  logic        done_dz_in = 1'b0;
  logic        busy;
  logic [7:0]  drop_cnt;

  always #10 clk_50m = ~clk_50m;

  spectrum_matrix_renderer #(
    .BANDS(BANDS), .HEIGHT(HEIGHT), .ADDR_W(5), .MAG_W(16), .SERPENTINE(1),
    .PEAK_DECAY(PEAK_DECAY)
  ) dut (
    .clk_50m(clk_50m), .rst(rst), .spec_frame_stb(spec_frame_stb),
    .spec_rd_addr(spec_rd_addr), .spec_rd_en(spec_rd_en), .spec_rd_data(spec_rd_data),
    .spec_rd_data_valid(spec_rd_data_valid), .mode(mode), .brightness(brightness),
    .led_data(led_data), .valid(valid), .start(start), .done_bit_in(done_bit_in),
    .done_dz_in(done_dz_in), .busy(busy), .drop_cnt(drop_cnt)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [23:0] exp_q[$];
  int          consumed = 0;
  int          frame_base = 0;
  int          start_cnt = 0;
  logic [23:0] cap [NPIX];
  int          rd_lat = 1;
  int          hold = 0;
  bit          spur = 1'b1;
  int unsigned mags [BANDS];
  int          m_peak [BANDS];
  int          m_fcnt = 0;
  int          exp_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] scale_px(input logic [23:0] px, input logic [7:0] b);
    int g, r, bl;
    if (b == 8'hFF) return px;
    g  = (int'(px[23:16]) * int'(b)) / 256;
    r  = (int'(px[15:8]) * int'(b)) / 256;
    bl = (int'(px[7:0]) * int'(b)) / 256;
    return {8'(g), 8'(r), 8'(bl)};
  endfunction

  // Reference frame: quantise, update the peak model, emit pixels in wire order.
  task automatic push_frame(input logic [1:0] m, input logic [7:0] b);
    int lvl [BANDS];
    bit tick;
    int row;
    bit lit;
    logic [23:0] px;
    tick = (m_fcnt == PEAK_DECAY - 1);
    for (int k = 0; k < BANDS; k++) begin
      lvl[k] = int'((mags[k] * 9) >> 16);
`ifdef SPECTRUM_RENDER_PEAK_EN
      if (lvl[k] > m_peak[k]) m_peak[k] = lvl[k];
      else if (tick && m_peak[k] > lvl[k]) m_peak[k] = m_peak[k] - 1;
`endif
    end
    m_fcnt = tick ? 0 : m_fcnt + 1;
    for (int k = 0; k < BANDS; k++) begin
      for (int i = 0; i < HEIGHT; i++) begin
        row = (k % 2 == 1) ? (HEIGHT - 1 - i) : i;
        lit = (m == 2'd1) ? (lvl[k] > 0 && row == lvl[k] - 1) : (row < lvl[k]);
        px  = 24'h000000;
        if (lit) px = (row < 4) ? 24'hFF0000 : ((row < 6) ? 24'hFFFF00 : 24'h00FF00);
`ifdef SPECTRUM_RENDER_PEAK_EN
        if (m == 2'd2 && m_peak[k] > lvl[k] && row == m_peak[k] - 1) px = 24'hFFFFFF;
`endif
        exp_q.push_back(scale_px(px, b));
      end
    end
  endtask

  // Spectrum RAM: answers each read request after rd_lat cycles.
  initial begin : rd_resp
    int a;
    forever begin
      @(posedge clk_50m); #1;
      if (spec_rd_en && !rst) begin
        a = int'(spec_rd_addr);
        if (rd_lat > 1) begin
          repeat (rd_lat - 1) @(posedge clk_50m);
          #1;
        end
        spec_rd_data = 16'(mags[a]);
        spec_rd_data_valid = 1'b1;
        @(posedge clk_50m); #1;
        spec_rd_data_valid = 1'b0;
      end
    end
  end

  // Driver model: consumes a pixel after 'hold' stall cycles; random done while not valid.
  initial begin : drv
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk_50m); #1;
      if (rst) begin
        done_bit_in = 1'b0;
        wcnt = 0;
      end else if (valid) begin
        if (wcnt >= hold) begin
          done_bit_in = 1'b1;
          wcnt = 0;
        end else begin
          done_bit_in = 1'b0;
          wcnt++;
        end
      end else begin
        done_bit_in = spur && ($urandom_range(0, 3) == 0);
        wcnt = 0;
      end
    end
  end

  // Monitor: scoreboard pops on every consumed pixel, and held pixels must not change.
  initial begin : mon
    logic        prev_valid, prev_done;
    logic [23:0] prev_led, e;
    int          idx;
    prev_valid = 1'b0;
    prev_done  = 1'b0;
    prev_led   = '0;
    forever begin
      @(negedge clk_50m);
      if (start) start_cnt++;
      if (rst) begin
        prev_valid = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (valid && prev_valid && !prev_done) check("hold_stable", led_data, prev_led);
        if (valid && done_bit_in) begin
          idx = consumed - frame_base;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_pixel: got %0h, expected no pixel", led_data);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("pixel%0d", idx), led_data, e);
          end
          if (idx >= 0 && idx < NPIX) cap[idx] = led_data;
          consumed++;
        end
        prev_valid = valid;
        prev_done  = done_bit_in;
        prev_led   = led_data;
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_led"}, led_data, 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd_en"}, spec_rd_en, 0);
    check({tag, "_rd_addr"}, spec_rd_addr, 0);
    check({tag, "_drop"}, drop_cnt, 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk_50m); #1;
    rst = 1'b1;
    spec_frame_stb = 1'b0;
    @(negedge clk_50m);
    check_zero(tag);
    exp_q.delete();
    for (int k = 0; k < BANDS; k++) m_peak[k] = 0;
    m_fcnt = 0;
    exp_drop = 0;
    repeat (2) @(posedge clk_50m);
    #1;
    rst = 1'b0;
  endtask

  task automatic strobe(input logic [1:0] m, input logic [7:0] b);
    @(posedge clk_50m); #1;
    mode = m;
    brightness = b;
    spec_frame_stb = 1'b1;
    @(posedge clk_50m); #1;
    spec_frame_stb = 1'b0;
    mode = ~m;
    brightness = ~b;
  endtask

  task automatic run_frame(input string tag, input logic [1:0] m, input logic [7:0] b,
                           input bit spam);
    int cyc, s0;
    push_frame(m, b);
    s0 = start_cnt;
    frame_base = consumed;
    strobe(m, b);
    cyc = 0;
    while (1) begin
      @(posedge clk_50m); #1;
      spec_frame_stb = 1'b0;
      if (consumed - frame_base >= NPIX || cyc >= LIMIT) break;
      cyc++;
      if (spam && cyc % 100 == 0) begin
        spec_frame_stb = 1'b1;
        if (exp_drop < 255) exp_drop++;
      end
    end
    if (cyc >= LIMIT) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got %0d pixels, expected %0d", tag, consumed - frame_base,
               NPIX);
      return;
    end
    repeat (3) @(posedge clk_50m);
    #1;
    check({tag, "_busy_in_dz"}, busy, 1);
    check({tag, "_valid_in_dz"}, valid, 0);
    done_dz_in = 1'b1;
    @(posedge clk_50m); #1;
    done_dz_in = 1'b0;
    @(negedge clk_50m);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_starts"}, start_cnt - s0, 1);
    check({tag, "_drop"}, drop_cnt, exp_drop);
    check({tag, "_npix"}, consumed - frame_base, NPIX);
    check({tag, "_queue"}, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cyc;
    for (int k = 0; k < BANDS; k++) m_peak[k] = 0;
    do_reset("reset");

    // Full-scale bars, brightness 255, read latency 1.
    for (int k = 0; k < BANDS; k++) mags[k] = 32'hFFFF;
    rd_lat = 1;
    hold = 0;
    run_frame("bar_full", 2'd0, 8'd255, 1'b0);
    check("bar_c0r0", cap[0], 24'hFF0000);
    check("bar_c0r3", cap[3], 24'hFF0000);
    check("bar_c0r4", cap[4], 24'hFFFF00);
    check("bar_c0r5", cap[5], 24'hFFFF00);
    check("bar_c0r6", cap[6], 24'h00FF00);
    check("bar_c0r7", cap[7], 24'h00FF00);
    check("bar_c1_first", cap[8], 24'h00FF00);
    check("bar_c1_last", cap[15], 24'hFF0000);

    // Brightness 128, mode 3, latency 5, strobes every 100 cycles while busy.
    rd_lat = 5;
    run_frame("bright128", 2'd3, 8'd128, 1'b1);
    check("b128_c0r0", cap[0], 24'h7F0000);
    check("b128_c0r4", cap[4], 24'h7F7F00);
    check("b128_c0r7", cap[7], 24'h007F00);
    check("b128_dropped", drop_cnt != 0, 1);

    // Ramp in dot mode: level = k*9/32.
    for (int k = 0; k < BANDS; k++) mags[k] = k * 2048;
    hold = 1;
    run_frame("dot", 2'd1, 8'd255, 1'b0);
    check("dot_c0_dark", cap[0], 24'h000000);
    check("dot_c3_dark", cap[24], 24'h000000);
    check("dot_c4r0", cap[32], 24'hFF0000);
    check("dot_c4r1", cap[33], 24'h000000);
    check("dot_c7r0", cap[63], 24'hFF0000);
    check("dot_c7r7", cap[56], 24'h000000);
    check("dot_c31r7", cap[248], 24'h00FF00);

    // Driver withholds done for 50 cycles on every pixel.
    for (int k = 0; k < BANDS; k++) mags[k] = 32'hFFFF;
    rd_lat = 1;
    hold = 50;
    run_frame("stall", 2'd0, 8'd255, 1'b0);
    check("stall_c0r0", cap[0], 24'hFF0000);
    hold = 0;

    // Reset in the middle of pixel streaming, then a clean frame.
    push_frame(2'd0, 8'd255);
    frame_base = consumed;
    strobe(2'd0, 8'd255);
    cyc = 0;
    while (consumed - frame_base < 40 && cyc < LIMIT) begin
      @(posedge clk_50m);
      cyc++;
    end
    check("abort_reached_emit", valid, 1);
    do_reset("abort");
    run_frame("after_abort", 2'd0, 8'd255, 1'b0);
    check("abort_c0r0", cap[0], 24'hFF0000);
    check("abort_last", cap[255], 24'hFF0000);

    // Peak hold: full frame then silence, mode 2, decay every 4th frame.
    do_reset("peak_reset");
    run_frame("peak_f1", 2'd2, 8'd255, 1'b0);
    check("peak_f1_top", cap[7], 24'h00FF00);
    for (int k = 0; k < BANDS; k++) mags[k] = 0;
    run_frame("peak_f2", 2'd2, 8'd255, 1'b0);
`ifdef SPECTRUM_RENDER_PEAK_EN
    check("peak_f2_r7", cap[7], 24'hFFFFFF);
    check("peak_f2_r6", cap[6], 24'h000000);
`else
    check("nopeak_f2_r7", cap[7], 24'h000000);
`endif
    run_frame("peak_f3", 2'd2, 8'd255, 1'b0);
`ifdef SPECTRUM_RENDER_PEAK_EN
    check("peak_f3_r7", cap[7], 24'hFFFFFF);
`endif
    run_frame("peak_f4", 2'd2, 8'd255, 1'b0);
`ifdef SPECTRUM_RENDER_PEAK_EN
    check("peak_f4_r7", cap[7], 24'h000000);
    check("peak_f4_r6", cap[6], 24'hFFFFFF);
    check("peak_f4_c1r6", cap[9], 24'hFFFFFF);
`else
    check("nopeak_f4_r6", cap[6], 24'h000000);
`endif
    run_frame("peak_f5", 2'd2, 8'd255, 1'b0);
`ifdef SPECTRUM_RENDER_PEAK_EN
    check("peak_f5_r6", cap[6], 24'hFFFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
